// File: rtl/gray_code_pipe_if.sv
// Handshake bundle for gray_code_pipe: input beat (valid/ready/mode/data) and
// output beat (valid/ready/data/mode/step_err).
interface gray_code_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_mode;
  logic             step_err;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_mode, step_err
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_mode, step_err
  );
endinterface

// File: rtl/gray_code_pipe.sv
// Pipelined Gray<->binary converter with valid/ready flow control and a
// single-bit-step check on consecutive Gray inputs.
module gray_code_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  gray_code_pipe_if.slave bus
);

  localparam int LAST = STAGES - 1;

  logic [WIDTH-1:0] g2b;
  logic [WIDTH-1:0] b2g;
  logic [WIDTH-1:0] conv;
  logic             accept;
  logic             err_in;

  logic [WIDTH-1:0] hist;
  logic             hist_valid;

  logic [STAGES-1:0] load;

  logic             stage_valid [STAGES];
  logic [WIDTH-1:0] stage_data  [STAGES];
  logic             stage_mode  [STAGES];
  logic             stage_err   [STAGES];

  logic             src_valid [STAGES];
  logic [WIDTH-1:0] src_data  [STAGES];
  logic             src_mode  [STAGES];
  logic             src_err   [STAGES];

  // Gray->binary is a prefix XOR running down from the MSB.
  always_comb begin
    g2b = '0;
    g2b[WIDTH-1] = bus.in_data[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      g2b[i] = bus.in_data[i] ^ g2b[i+1];
    end
  end

  assign b2g    = bus.in_data ^ (bus.in_data >> 1);
  assign conv   = bus.in_mode ? b2g : g2b;
  assign accept = bus.in_valid && bus.in_ready;

  // A clr in the same cycle as a Gray beat makes that beat the first of a new history.
  assign err_in = !bus.in_mode && hist_valid && !clr &&
                  ($countones(bus.in_data ^ hist) != 1);

  // A stage can load if it is empty or its beat moves on this edge.
  always_comb begin
    logic take;
    load = '0;
    take = bus.out_ready;
    for (int k = LAST; k >= 0; k--) begin
      load[k] = !stage_valid[k] || take;
      take    = load[k];
    end
  end

  assign bus.in_ready = load[0];

  always_comb begin
    src_valid[0] = accept;
    src_data[0]  = conv;
    src_mode[0]  = bus.in_mode;
    src_err[0]   = err_in;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = stage_valid[k-1];
      src_data[k]  = stage_data[k-1];
      src_mode[k]  = stage_mode[k-1];
      src_err[k]   = stage_err[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_valid[k] <= 1'b0;
        stage_data[k]  <= '0;
        stage_mode[k]  <= 1'b0;
        stage_err[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          stage_valid[k] <= src_valid[k];
          stage_data[k]  <= src_data[k];
          stage_mode[k]  <= src_mode[k];
          stage_err[k]   <= src_err[k];
        end
      end
    end
  end

  // Only accepted Gray beats advance the history; clr alone just empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist       <= '0;
      hist_valid <= 1'b0;
    end else if (accept && !bus.in_mode) begin
      hist       <= bus.in_data;
      hist_valid <= 1'b1;
    end else if (clr) begin
      hist_valid <= 1'b0;
    end
  end

  assign bus.out_valid = stage_valid[LAST];
  assign bus.out_data  = stage_data[LAST];
  assign bus.out_mode  = stage_mode[LAST];
  assign bus.step_err  = stage_err[LAST];

endmodule

// File: tb/tb_gray_code_pipe.sv
// Scoreboard bench for gray_code_pipe (WIDTH=4, STAGES=2): expected beats are
// queued at acceptance and compared as they leave the pipeline.
module tb_gray_code_pipe;

  localparam int WIDTH  = 4;
  localparam int STAGES = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  gray_code_pipe_if #(.WIDTH(WIDTH)) bus ();

  gray_code_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             mode;
    logic             err;
    int               accCycle;
    logic             timed;
  } beat_t;

  beat_t            scoreboard[$];
  int               checks      = 0;
  int               errors      = 0;
  int               cycle       = 0;
  logic [WIDTH-1:0] histModel   = '0;
  logic             histValid   = 1'b0;
  logic             latencyMode = 1'b0;
  logic [WIDTH-1:0] lastOut     = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [WIDTH-1:0] modelConvert(input logic mode,
                                                    input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = '0;
    if (mode) r = d ^ (d >> 1);
    else for (int i = 0; i < WIDTH; i++) r[i] = ^(d >> i);
    return r;
  endfunction

  // Drives one beat from the negedge, waits (bounded) for ready, queues the
  // expectation and returns right after the accepting edge.
  task automatic applyStimulus(input logic mode, input logic [WIDTH-1:0] data,
                               input logic doClr, input logic expectReady);
    beat_t b;
    int    waited;
    waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_data  = data;
    clr          = doClr;
    #1;
    if (expectReady) checkOutput("in_ready_stream", 32'(bus.in_ready), 32'd1);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bus.in_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      clr          = 1'b0;
      return;
    end
    b.data = modelConvert(mode, data);
    b.mode = mode;
    b.err  = 1'b0;
    if (!mode) begin
      b.err     = (histValid && !doClr) ? ($countones(data ^ histModel) != 1) : 1'b0;
      histModel = data;
      histValid = 1'b1;
    end
    b.accCycle = cycle + 1;
    b.timed    = latencyMode;
    scoreboard.push_back(b);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    clr          = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (scoreboard.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(scoreboard.size()), 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Samples between edges; a stalled beat must reappear unchanged next sample.
  initial begin
    logic             prevStall;
    logic [WIDTH-1:0] hD;
    logic             hM;
    logic             hE;
    beat_t            e;
    prevStall = 1'b0;
    hD = '0;
    hM = 1'b0;
    hE = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
          checkOutput("hold_data", 32'(bus.out_data), 32'(hD));
          checkOutput("hold_mode", 32'(bus.out_mode), 32'(hM));
          checkOutput("hold_err", 32'(bus.step_err), 32'(hE));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (scoreboard.size() == 0) begin
            checkOutput("unexpected_beat", 32'd1, 32'd0);
          end else begin
            e = scoreboard.pop_front();
            checkOutput("out_data", 32'(bus.out_data), 32'(e.data));
            checkOutput("out_mode", 32'(bus.out_mode), 32'(e.mode));
            checkOutput("step_err", 32'(bus.step_err), 32'(e.err));
            if (e.timed) checkOutput("latency", 32'(cycle - e.accCycle), 32'(STAGES - 1));
            lastOut = bus.out_data;
          end
        end
        prevStall = bus.out_valid && !bus.out_ready;
        hD = bus.out_data;
        hM = bus.out_mode;
        hE = bus.step_err;
      end
    end
  end

  initial begin
    #200000;
    checkOutput("watchdog", 32'd0, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    #12;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("rst_out_mode", 32'(bus.out_mode), 32'd0);
    checkOutput("rst_step_err", 32'(bus.step_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single Gray->binary and binary->Gray beats");
    latencyMode = 1'b1;
    applyStimulus(1'b0, 4'b1101, 1'b0, 1'b0);
    idle();
    waitDrain();
    checkOutput("g2b_1101", 32'(lastOut), 32'b1001);
    applyStimulus(1'b1, 4'b1001, 1'b0, 1'b0);
    idle();
    waitDrain();
    checkOutput("b2g_1001", 32'(lastOut), 32'b1101);

    $display("[TB] back-to-back Gray count");
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b0001, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b0011, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b0010, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b0110, 1'b0, 1'b1);
    idle();
    waitDrain();
    checkOutput("count_last", 32'(lastOut), 32'd4);

    $display("[TB] step check and clr");
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0011, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0111, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0);
    idle();
    waitDrain();

    $display("[TB] backpressure stream");
    latencyMode = 1'b0;
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
    idle();
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 4'h4, 1'b0, 1'b0);
    idle();
    #1;
    checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h6, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h7, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'hE, 1'b0, 1'b0);
    idle();
    waitDrain();

    $display("[TB] reset with beats in flight");
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 4'h9, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hA, 1'b0, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    scoreboard.delete();
    histValid = 1'b0;
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    latencyMode   = 1'b1;
    applyStimulus(1'b0, 4'b0101, 1'b0, 1'b0);
    idle();
    waitDrain();
    checkOutput("post_rst_first", 32'(lastOut), 32'b0110);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
